// File: rtl/btn_event.sv
// btn_event: classifies a filtered push-button level into single-cycle event
// pulses (rise, fall, short press, long press, auto-repeat, double click).
// It also reports a saturating hold-duration count.
// All outputs are registered. At most one of the press-class events
// (short_press, long_press, repeat_tick, dbl_click) is high in any cycle.
//
// The auto-repeat output is named repeat_tick because "repeat" is a reserved
// word in SystemVerilog.
module btn_event #(
  parameter int LONG_CYC    = 1000,
  parameter int REPEAT_CYC  = 200,
  parameter int DBL_GAP_CYC = 300,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             rise,
  output logic             fall,
  output logic             short_press,
  output logic             long_press,
  output logic             repeat_tick,
  output logic             dbl_click,
  output logic [CNT_W-1:0] hold_cnt
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (LONG_CYC < 2) begin : g_bad_long_cyc
    $error("btn_event: LONG_CYC must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("btn_event: CNT_W must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Timer sizing: wide enough for the largest interval, plus one spare bit so
  // the saturation value is always above every compare point.
  // ---------------------------------------------------------------------------
  localparam int MAX_LR  = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int MAX_CYC = (MAX_LR > DBL_GAP_CYC) ? MAX_LR : DBL_GAP_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam bit REP_EN = (REPEAT_CYC > 0);
  localparam bit GAP_EN = (DBL_GAP_CYC > 0);

  // Terminal timer values. A disabled feature gets a harmless 0, because its
  // compare is gated by the enable bit.
  localparam int LONG_LAST_I = LONG_CYC - 1;
  localparam int REP_LAST_I  = REP_EN ? (REPEAT_CYC - 1) : 0;
  localparam int GAP_LAST_I  = GAP_EN ? (DBL_GAP_CYC - 1) : 0;

  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_LAST_I);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REP_LAST_I);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_LAST_I);
  localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;  // released, nothing pending
  localparam logic [2:0] S_HELD  = 3'd1;  // first press in progress
  localparam logic [2:0] S_LONG  = 3'd2;  // long press reached, repeating
  localparam logic [2:0] S_GAP   = 3'd3;  // released, waiting for a 2nd press
  localparam logic [2:0] S_HELD2 = 3'd4;  // second press of a double click

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic             in_q;
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic rise_q,   rise_d;
  logic fall_q,   fall_d;
  logic short_q,  short_d;
  logic long_q,   long_d;
  logic rpt_q,    rpt_d;
  logic dbl_q,    dbl_d;

  logic rise_edge;
  logic fall_edge;
  logic tmr_restart;

  // Edge detection against the previous sample of the filtered level.
  always_comb begin
    rise_edge = in & ~in_q;
    fall_edge = ~in & in_q;
  end

  // Press FSM: the next state and the press-class event for this edge.
  always_comb begin
    state_d     = state_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    rpt_d       = 1'b0;
    dbl_d       = 1'b0;
    tmr_restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise_edge) begin
          state_d = S_HELD;
        end
      end

      S_HELD: begin
        // A release on the same edge as the long threshold counts as a
        // short press, so the release is checked first.
        if (fall_edge) begin
          if (GAP_EN) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            short_d = 1'b1;
          end
        end else if (tmr_q == LONG_LAST) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end

      S_LONG: begin
        // A release ends the hold silently. The release edge never carries
        // a repeat.
        if (fall_edge) begin
          state_d = S_IDLE;
        end else if (REP_EN && (tmr_q == REP_LAST)) begin
          rpt_d       = 1'b1;
          tmr_restart = 1'b1;
        end
      end

      S_GAP: begin
        // A second press on the timeout edge still counts as a double click.
        if (rise_edge) begin
          state_d = S_HELD2;
        end else if (tmr_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end

      S_HELD2: begin
        // If the second press turns into a long press, the first click is
        // dropped.
        if (fall_edge) begin
          state_d = S_IDLE;
          dbl_d   = 1'b1;
        end else if (tmr_q == LONG_LAST) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Interval timer: restarts on every state change and on each repeat tick.
  // Otherwise it counts up and sticks at all-ones.
  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) || tmr_restart) begin
      tmr_d = '0;
    end else if (tmr_q != TMR_MAX) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  // Hold-duration counter: starts at 1 on the press edge, counts while the
  // level stays high, and freezes after release until the next press.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (rise_edge) begin
      hold_cnt_d = CNT_ONE;
    end else if (in && in_q && (hold_cnt_q != CNT_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Rise and fall pulse on every edge, independent of FSM state.
  always_comb begin
    rise_d = rise_edge;
    fall_d = fall_edge;
  end

  // All state and output registers, with a synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= 1'b0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      hold_cnt_q <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
      dbl_q      <= 1'b0;
    end else begin
      in_q       <= in;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      hold_cnt_q <= hold_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      short_q    <= short_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
      dbl_q      <= dbl_d;
    end
  end

  // Drive the ports straight from the output registers.
  always_comb begin
    rise        = rise_q;
    fall        = fall_q;
    short_press = short_q;
    long_press  = long_q;
    repeat_tick = rpt_q;
    dbl_click   = dbl_q;
    hold_cnt    = hold_cnt_q;
  end

endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed stimulus for btn_event.
// It uses LONG=10, REPEAT=4, GAP=6 and CNT_W=4, plus a second instance with
// double-click detection disabled. Events are checked as the vector
// {rise, fall, short_press, long_press, repeat_tick, dbl_click}.
module tb_btn_event;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_a, in_b;
  logic       rise_a, fall_a, sp_a, lp_a, rp_a, dc_a;
  logic       rise_b, fall_b, sp_b, lp_b, rp_b, dc_b;
  logic [3:0] hc_a, hc_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  btn_event #(.LONG_CYC(10), .REPEAT_CYC(4), .DBL_GAP_CYC(6), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .rise(rise_a), .fall(fall_a), .short_press(sp_a), .long_press(lp_a),
    .repeat_tick(rp_a), .dbl_click(dc_a), .hold_cnt(hc_a)
  );

  btn_event #(.LONG_CYC(10), .REPEAT_CYC(4), .DBL_GAP_CYC(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in(in_b),
    .rise(rise_b), .fall(fall_b), .short_press(sp_b), .long_press(lp_b),
    .repeat_tick(rp_b), .dbl_click(dc_b), .hold_cnt(hc_b)
  );

  function automatic logic [5:0] ev(bit r, bit f, bit s, bit l, bit p, bit d);
    return {r, f, s, l, p, d};
  endfunction

  function automatic logic [5:0] obs_a();
    return {rise_a, fall_a, sp_a, lp_a, rp_a, dc_a};
  endfunction

  function automatic logic [5:0] obs_b();
    return {rise_b, fall_b, sp_b, lp_b, rp_b, dc_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ev(string tag, int k, logic [5:0] obs, logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_cnt(string tag, logic [3:0] obs, logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_a = 1'b0;
    in_b = 1'b0;
    tick(); tick(); tick();
    chk_ev("reset_ev_a", 0, obs_a(), 6'b0);
    chk_cnt("reset_cnt_a", hc_a, 4'd0);
    chk_ev("reset_ev_b", 0, obs_b(), 6'b0);
    rst = 1'b0;
    tick(); tick();

    // S1: hold 20 -> long at 10, repeats at 14 and 18, silent fall at 20
    for (int k = 0; k < 30; k++) begin
      in_a = (k < 20);
      tick();
      chk_ev("s1_long_hold", k, obs_a(), ev(k == 0, k == 20, 0, k == 10, (k == 14) || (k == 18), 0));
    end
    chk_cnt("s1_hold_sat", hc_a, 4'd15);

    // S2: hold 3, release 10 -> short press 6 cycles after the fall
    for (int k = 0; k < 14; k++) begin
      in_a = (k < 3);
      tick();
      chk_ev("s2_short", k, obs_a(), ev(k == 0, k == 3, k == 9, 0, 0, 0));
    end
    chk_cnt("s2_hold_cnt", hc_a, 4'd3);

    // S3: hold 3, release 2, hold 3 -> double click on the second fall
    for (int k = 0; k < 20; k++) begin
      in_a = (k < 3) || ((k >= 5) && (k < 8));
      tick();
      chk_ev("s3_dbl", k, obs_a(), ev((k == 0) || (k == 5), (k == 3) || (k == 8), 0, 0, 0, k == 8));
    end
    chk_cnt("s3_hold_cnt", hc_a, 4'd3);

    // S4: second press lands on the gap timeout edge -> still a double click
    for (int k = 0; k < 25; k++) begin
      in_a = (k < 3) || ((k >= 9) && (k < 12));
      tick();
      chk_ev("s4_dbl_edge", k, obs_a(), ev((k == 0) || (k == 9), (k == 3) || (k == 12), 0, 0, 0, k == 12));
    end

    // S5: release on the long-threshold edge -> short press via the gap timeout
    for (int k = 0; k < 20; k++) begin
      in_a = (k < 10);
      tick();
      chk_ev("s5_fall_wins", k, obs_a(), ev(k == 0, k == 10, k == 16, 0, 0, 0));
    end
    chk_cnt("s5_hold_cnt", hc_a, 4'd10);

    // S6: no double-click window -> short press together with the fall
    for (int k = 0; k < 8; k++) begin
      in_b = (k < 3);
      tick();
      chk_ev("s6_nogap_short", k, obs_b(), ev(k == 0, k == 3, k == 3, 0, 0, 0));
    end
    chk_cnt("s6_hold_cnt", hc_b, 4'd3);

    // S7: reset in the middle of a long hold, with the level kept high
    for (int k = 0; k < 16; k++) begin
      in_a = 1'b1;
      tick();
      chk_ev("s7_pre_long", k, obs_a(), ev(k == 0, 0, 0, k == 10, k == 14, 0));
    end
    rst = 1'b1;
    tick();
    chk_ev("s7_rst_ev", 0, obs_a(), 6'b0);
    chk_cnt("s7_rst_cnt", hc_a, 4'd0);
    tick();
    chk_ev("s7_rst_ev", 1, obs_a(), 6'b0);
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      in_a = (k < 13);
      tick();
      chk_ev("s7_post_rst", k, obs_a(), ev(k == 0, k == 13, 0, k == 10, 0, 0));
    end
    chk_cnt("s7_hold_cnt", hc_a, 4'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time limit so that the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
